// File: rtl/pe_ctrl_my.sv
// ---------------------------------------------------------------------------
// pe_ctrl_my
//   Upstream sequencer for a single MAC processing element (PE) that owns a
//   2**L_RAM_SIZE x 8b local RAM. Each start pulse runs one dot product:
//   the first N stream beats are written into the PE RAM as vector B (LOAD),
//   the next N beats are issued on pe_ain as vector A, aligned with the PE's
//   one-cycle RAM read (CALC). The controller then waits for the PE to drain,
//   captures the 16b sum into result and pulses done.
//
// Ports
//   aclk      in   1   clock, all logic on posedge
//   areset    in   1   asynchronous active-high reset
//   start     in   1   begin one run, sampled only in IDLE
//   s_data    in   8   stream data: N B-words, then N A-words
//   s_valid   in   1   s_data valid
//   s_ready   out  1   controller accepts s_data this cycle
//   pe_din    out  8   PE RAM write data
//   pe_addr   out  L   PE RAM address (write and read)
//   pe_we     out  1   PE RAM write enable
//   pe_ain    out  8   PE port-A operand
//   pe_valid  out  1   pe_ain valid, aligned with PE RAM read data
//   pe_clr_n  out  1   active-low PE accumulator clear
//   pe_dout   in   16  PE accumulated result
//   busy      out  1   high in every state except IDLE
//   done      out  1   one-cycle pulse when result is updated
//   result    out  16  last captured dot product
// ---------------------------------------------------------------------------
module pe_ctrl_my #(
  parameter int L_RAM_SIZE = 3,
  parameter int PE_LAT     = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [7:0]            pe_din,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic                  pe_we,
  output logic [7:0]            pe_ain,
  output logic                  pe_valid,
  output logic                  pe_clr_n,
  input  logic [15:0]           pe_dout,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           result
);

  // Drain counter must hold 1+PE_LAT.
  localparam int DW = $clog2(PE_LAT + 2);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(PE_LAT + 1);
  localparam logic [L_RAM_SIZE-1:0] CNT_LAST = {L_RAM_SIZE{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CALC  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [L_RAM_SIZE-1:0]   cnt_r, cnt_s;
  logic [DW-1:0]           drain_r, drain_s;
  // One-stage pipeline that delays A by a cycle so it meets the RAM read data.
  logic [7:0]              a_pipe_r, a_pipe_s;
  logic                    a_vld_r, a_vld_s;

  logic                    s_ready_r, s_ready_s;
  logic [7:0]              pe_din_r, pe_din_s;
  logic [L_RAM_SIZE-1:0]   pe_addr_r, pe_addr_s;
  logic                    pe_we_r, pe_we_s;
  logic [7:0]              pe_ain_r, pe_ain_s;
  logic                    pe_valid_r, pe_valid_s;
  logic                    pe_clr_n_r, pe_clr_n_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic [15:0]             result_r, result_s;

  logic                    beat_s;

  // Handshake seen by the controller; s_ready is a register so this is glitch-free.
  assign beat_s = s_valid & s_ready_r;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    drain_s    = drain_r;
    a_pipe_s   = a_pipe_r;
    a_vld_s    = 1'b0;
    s_ready_s  = 1'b0;
    pe_din_s   = pe_din_r;
    pe_addr_s  = pe_addr_r;
    pe_we_s    = 1'b0;
    pe_ain_s   = a_pipe_r;
    pe_valid_s = a_vld_r;
    pe_clr_n_s = 1'b1;
    busy_s     = 1'b1;
    done_s     = 1'b0;
    result_s   = result_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_LOAD;
          cnt_s      = {L_RAM_SIZE{1'b0}};
          pe_clr_n_s = 1'b0;
          s_ready_s  = 1'b1;
          busy_s     = 1'b1;
        end else begin
          state_s    = ST_IDLE;
          busy_s     = 1'b0;
        end
      end

      ST_LOAD: begin
        s_ready_s = 1'b1;
        if (beat_s) begin
          pe_we_s   = 1'b1;
          pe_addr_s = cnt_r;
          pe_din_s  = s_data;
          cnt_s     = cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_s = ST_CALC;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end

      ST_CALC: begin
        s_ready_s = 1'b1;
        if (beat_s) begin
          // Address goes out now; the operand follows a cycle later with the read data.
          pe_addr_s = cnt_r;
          a_pipe_s  = s_data;
          a_vld_s   = 1'b1;
          cnt_s     = cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_s   = ST_DRAIN;
            drain_s   = DRAIN_INIT;
            s_ready_s = 1'b0;
          end else begin
            state_s   = ST_CALC;
          end
        end else begin
          state_s = ST_CALC;
        end
      end

      ST_DRAIN: begin
        // The done cycle is still spent in DRAIN so a start there is ignored.
        if (done_r) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else if (drain_r == {DW{1'b0}}) begin
          state_s  = ST_DRAIN;
          done_s   = 1'b1;
          result_s = pe_dout;
        end else begin
          state_s  = ST_DRAIN;
          drain_s  = drain_r - 1'b1;
        end
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters, pipeline and output registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {L_RAM_SIZE{1'b0}};
      drain_r    <= {DW{1'b0}};
      a_pipe_r   <= 8'd0;
      a_vld_r    <= 1'b0;
      s_ready_r  <= 1'b0;
      pe_din_r   <= 8'd0;
      pe_addr_r  <= {L_RAM_SIZE{1'b0}};
      pe_we_r    <= 1'b0;
      pe_ain_r   <= 8'd0;
      pe_valid_r <= 1'b0;
      pe_clr_n_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= 16'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      drain_r    <= drain_s;
      a_pipe_r   <= a_pipe_s;
      a_vld_r    <= a_vld_s;
      s_ready_r  <= s_ready_s;
      pe_din_r   <= pe_din_s;
      pe_addr_r  <= pe_addr_s;
      pe_we_r    <= pe_we_s;
      pe_ain_r   <= pe_ain_s;
      pe_valid_r <= pe_valid_s;
      pe_clr_n_r <= pe_clr_n_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      result_r   <= result_s;
    end
  end

  assign s_ready  = s_ready_r;
  assign pe_din   = pe_din_r;
  assign pe_addr  = pe_addr_r;
  assign pe_we    = pe_we_r;
  assign pe_ain   = pe_ain_r;
  assign pe_valid = pe_valid_r;
  assign pe_clr_n = pe_clr_n_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;

endmodule

// File: tb/tb_pe_ctrl_my.sv
// ---------------------------------------------------------------------------
// tb_pe_ctrl_my
//   Self-checking bench for pe_ctrl_my. A small PE model (8x8b RAM with a
//   one-cycle read and a 16b wrapping MAC) sits on the PE side; expected
//   results are the dot product of the vectors the bench streamed in.
// ---------------------------------------------------------------------------
module tb_pe_ctrl_my;

  logic        aclk;
  logic        areset;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  pe_din;
  logic [2:0]  pe_addr;
  logic        pe_we;
  logic [7:0]  pe_ain;
  logic        pe_valid;
  logic        pe_clr_n;
  logic [15:0] pe_dout;
  logic        busy;
  logic        done;
  logic [15:0] result;

  pe_ctrl_my #(.L_RAM_SIZE(3), .PE_LAT(1)) dut (
    .aclk(aclk), .areset(areset), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pe_din(pe_din), .pe_addr(pe_addr), .pe_we(pe_we),
    .pe_ain(pe_ain), .pe_valid(pe_valid), .pe_clr_n(pe_clr_n),
    .pe_dout(pe_dout), .busy(busy), .done(done), .result(result)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // PE model: RAM with registered read, MAC wrapping mod 2**16.
  logic [7:0]  ram [8];
  logic [7:0]  ram_q;
  logic [15:0] acc;
  always @(posedge aclk) begin
    if (pe_we) ram[pe_addr] <= pe_din;
    ram_q <= ram[pe_addr];
    if (!pe_clr_n) acc <= 16'd0;
    else if (pe_valid) acc <= acc + 16'(16'(pe_ain) * 16'(ram_q));
  end
  assign pe_dout = acc;

  // Activity monitor (totals only; the main sequence takes deltas).
  int we_tot = 0, vld_tot = 0, done_tot = 0, ovl_tot = 0;
  int run_len = 0, last_run_len = 0;
  always @(negedge aclk) begin
    if (!areset) begin
      if (pe_we) we_tot <= we_tot + 1;
      if (pe_valid) vld_tot <= vld_tot + 1;
      if (done) done_tot <= done_tot + 1;
      if (pe_we && pe_valid) ovl_tot <= ovl_tot + 1;
      if (pe_valid) run_len <= run_len + 1;
      else begin
        if (run_len != 0) last_run_len <= run_len;
        run_len <= 0;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [7:0] bv [8];
  logic [7:0] av [8];

  // One run: start, stream B then A, then wait for done and check everything.
  // mode 0: no gaps, 1: s_valid every other cycle, 2: random gaps.
  // rst_idx >= 0 asserts areset when that word is presented and returns.
  task automatic do_run(input int mode, input bit pulse_start, input int rst_idx);
    int idx, cyc, dcyc, s, we0, vld0, done0, ovl0;
    bit acc_b;
    logic [31:0] exp_sum;
    s = 0;
    for (int i = 0; i < 8; i++) s += int'(bv[i]) * int'(av[i]);
    exp_sum = 32'(s) & 32'h0000_FFFF;
    we0 = we_tot; vld0 = vld_tot; done0 = done_tot; ovl0 = ovl_tot;
    @(negedge aclk); start = 1'b1;
    @(negedge aclk); start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 16 && cyc < 200) begin
      case (mode)
        0: s_valid = 1'b1;
        1: s_valid = ((cyc % 2) == 0);
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_data = (idx < 8) ? bv[idx] : av[idx - 8];
      start = (pulse_start && idx == 3) ? 1'b1 : 1'b0;
      if (idx == rst_idx) begin
        s_valid = 1'b1;
        areset = 1'b1;
        return;
      end
      acc_b = s_valid && s_ready;
      @(posedge aclk);
      if (acc_b) idx++;
      @(negedge aclk);
      cyc++;
    end
    s_valid = 1'b0;
    start = 1'b0;
    check("stream_consumed", 32'(idx), 32'd16);
    if (pulse_start) begin
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
    end
    dcyc = 0;
    while (!done && dcyc < 20) begin
      @(negedge aclk);
      dcyc++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("result", 32'(result), exp_sum);
    // start in the done cycle must be ignored
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("s_ready_after_done", 32'(s_ready), 32'd0);
    @(negedge aclk);
    check("idle_s_ready", 32'(s_ready), 32'd0);
    check("result_held", 32'(result), exp_sum);
    @(negedge aclk);
    check("we_pulses", 32'(we_tot - we0), 32'd8);
    check("valid_pulses", 32'(vld_tot - vld0), 32'd8);
    check("we_valid_exclusive", 32'(ovl_tot - ovl0), 32'd0);
    check("done_count", 32'(done_tot - done0), 32'd1);
  endtask

  initial begin
    int d0;
    areset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    repeat (3) @(negedge aclk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_pe_we", 32'(pe_we), 32'd0);
    check("rst_pe_valid", 32'(pe_valid), 32'd0);
    check("rst_pe_din", 32'(pe_din), 32'd0);
    check("rst_pe_addr", 32'(pe_addr), 32'd0);
    check("rst_pe_ain", 32'(pe_ain), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_pe_clr_n", 32'(pe_clr_n), 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("clr_n_after_release", 32'(pe_clr_n), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // 1: B=1..8, A=1, no gaps -> 36, 8 consecutive pe_valid
    for (int i = 0; i < 8; i++) begin bv[i] = 8'(i + 1); av[i] = 8'd1; end
    do_run(0, 1'b0, -1);
    check("valid_run_len_nogap", 32'(last_run_len), 32'd8);

    // 2: same data with s_valid toggling -> isolated pe_valid pulses
    do_run(1, 1'b0, -1);
    check("valid_run_len_gap", 32'(last_run_len), 32'd1);

    // 3: two runs back to back, accumulator cleared between them
    for (int i = 0; i < 8; i++) begin bv[i] = 8'd2; av[i] = 8'd3; end
    do_run(0, 1'b0, -1);
    for (int i = 0; i < 8; i++) begin bv[i] = 8'd1; av[i] = 8'd1; end
    do_run(0, 1'b0, -1);

    // 4: all 255 -> 520200 mod 65536
    for (int i = 0; i < 8; i++) begin bv[i] = 8'd255; av[i] = 8'd255; end
    do_run(0, 1'b0, -1);

    // 6: start pulsed during LOAD and DRAIN is ignored
    for (int i = 0; i < 8; i++) begin bv[i] = 8'(i + 1); av[i] = 8'd1; end
    do_run(2, 1'b1, -1);

    // 5: areset at the 3rd CALC beat
    d0 = done_tot;
    for (int i = 0; i < 8; i++) begin bv[i] = 8'(8 - i); av[i] = 8'(i + 2); end
    do_run(0, 1'b0, 10);
    @(negedge aclk);
    s_valid = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_pe_we", 32'(pe_we), 32'd0);
    check("midrst_pe_valid", 32'(pe_valid), 32'd0);
    check("midrst_pe_addr", 32'(pe_addr), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_pe_clr_n", 32'(pe_clr_n), 32'd0);
    areset = 1'b0;
    repeat (6) @(negedge aclk);
    check("midrst_no_done", 32'(done_tot - d0), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    do_run(0, 1'b0, -1);

    // Random data and random stream gaps
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 8; i++) begin
        bv[i] = 8'($urandom_range(0, 255));
        av[i] = 8'($urandom_range(0, 255));
      end
      do_run(2, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
